// File: rtl/reg_write_queue_pkg.sv
// Shared widths, idle code and queue entry type for the
// register write-back path.
package reg_bank_pkg;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 4;
    localparam logic [ADDR_W-1:0] REG_IDLE = '1;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wb_entry_t;
endpackage

// File: rtl/reg_write_queue_if.sv
// Write-request handshake between execute/load units and
// the write-back queue.
interface reg_write_queue_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4
);
    logic              in_valid;
    logic              in_ready;
    logic [ADDR_W-1:0] in_addr;
    logic [DATA_W-1:0] in_data;

    modport master (
        output in_valid, in_addr, in_data,
        input  in_ready
    );
    modport slave (
        input  in_valid, in_addr, in_data,
        output in_ready
    );
endinterface

// File: rtl/reg_write_queue_fwd.sv
// Youngest-first search of pending queue entries for a
// forwarding read address.
module reg_fwd_match
    import reg_bank_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PW    = $clog2(DEPTH)
) (
    input  wb_entry_t         entries [DEPTH],
    input  logic [DEPTH-1:0]  valid,
    input  logic [PW-1:0]     head,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              hit,
    output logic [DATA_W-1:0] data
);
    logic [PW-1:0] idx;

    // Walk oldest to youngest so the youngest match is left standing.
    always_comb begin
        hit  = 1'b0;
        data = '0;
        idx  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head + PW'(i);
            if (valid[idx] && entries[idx].addr == rd_addr) begin
                hit  = 1'b1;
                data = entries[idx].data;
            end
        end
    end
endmodule

// File: rtl/reg_write_queue.sv
// Write-back FIFO in front of register_bank: drains one write per
// cycle and forwards pending data to readers.
module reg_write_queue #(
    parameter int DATA_W = reg_bank_pkg::DATA_W,
    parameter int ADDR_W = reg_bank_pkg::ADDR_W,
    parameter int DEPTH  = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    reg_write_queue_if.slave           wq,
    input  logic                       stall,
    output logic [ADDR_W-1:0]          reg_write,
    output logic [DATA_W-1:0]          reg_in,
    input  logic [ADDR_W-1:0]          rd_addr,
    output logic                       rd_hit,
    output logic [DATA_W-1:0]          rd_data,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       err
);
    import reg_bank_pkg::*;

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    wb_entry_t         mem [DEPTH];
    logic [PW-1:0]     rd_ptr;
    logic [PW-1:0]     wr_ptr;
    logic              take;
    logic              push;
    logic              pop;
    logic              bad;
    logic [DEPTH-1:0]  valid;
    logic [PW-1:0]     off;
    logic              q_hit;
    logic [DATA_W-1:0] q_data;
    logic              out_hit;

    assign wq.in_ready = (count < CW'(DEPTH));
    assign take = wq.in_valid && wq.in_ready;
    assign push = take && (wq.in_addr != REG_IDLE);
    assign bad  = take && (wq.in_addr == REG_IDLE);
    assign pop  = (count != '0) && !stall;

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= '0;
            reg_write <= REG_IDLE;
            reg_in    <= '0;
            err       <= 1'b0;
        end else begin
            err <= bad;
            if (push) begin
                mem[wr_ptr] <= '{addr: wq.in_addr, data: wq.in_data};
                wr_ptr      <= wr_ptr + PW'(1);
            end
            if (pop) begin
                reg_write <= mem[rd_ptr].addr;
                reg_in    <= mem[rd_ptr].data;
                rd_ptr    <= rd_ptr + PW'(1);
            end else begin
                reg_write <= REG_IDLE;
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

    // An entry is live when its distance from the head is below count.
    always_comb begin
        valid = '0;
        off   = '0;
        for (int k = 0; k < DEPTH; k++) begin
            off      = PW'(k) - rd_ptr;
            valid[k] = CW'(off) < count;
        end
    end

    reg_fwd_match #(.DEPTH(DEPTH), .PW(PW)) u_fwd (
        .entries (mem),
        .valid   (valid),
        .head    (rd_ptr),
        .rd_addr (rd_addr),
        .hit     (q_hit),
        .data    (q_data)
    );

    assign out_hit = (reg_write == rd_addr);
    assign rd_hit  = (rd_addr != REG_IDLE) && (q_hit || out_hit);
    assign rd_data = !rd_hit ? '0 : (q_hit ? q_data : reg_in);
endmodule

// File: tb/tb_reg_write_queue.sv
// Self-checking bench for reg_write_queue: directed sequences,
// a forwarding vector table and a FIFO-order scoreboard.
module tb_reg_write_queue;
    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic [3:0]  reg_write;
    logic [31:0] reg_in;
    logic [3:0]  rd_addr;
    logic        rd_hit;
    logic [31:0] rd_data;
    logic [2:0]  count;
    logic        err;

    int checks = 0;
    int errors = 0;
    logic [35:0] sb [$];

    reg_write_queue_if #(.DATA_W(32), .ADDR_W(4)) wq ();

    reg_write_queue #(.DATA_W(32), .ADDR_W(4), .DEPTH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .wq        (wq),
        .stall     (stall),
        .reg_write (reg_write),
        .reg_in    (reg_in),
        .rd_addr   (rd_addr),
        .rd_hit    (rd_hit),
        .rd_data   (rd_data),
        .count     (count),
        .err       (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  rd_addr;
        logic        exp_hit;
        logic [31:0] exp_data;
    } fwd_vec_t;

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [3:0] a,
                         input logic [31:0] d);
        wq.in_valid = v;
        wq.in_addr  = a;
        wq.in_data  = d;
    endtask

    // Reference order: every accepted non-idle request, popped as drained.
    always @(posedge clk) begin
        if (rst)
            sb.delete();
        else if (wq.in_valid && wq.in_ready && wq.in_addr != 4'hF)
            sb.push_back({wq.in_addr, wq.in_data});
    end

    always @(negedge clk) begin
        if (!rst && reg_write != 4'hF) begin
            logic [35:0] e;
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected: got %0h/%0h expected none",
                         reg_write, reg_in);
            end else begin
                e = sb.pop_front();
                if ({reg_write, reg_in} !== e) begin
                    errors++;
                    $display("FAIL sb_order: got %0h/%0h expected %0h/%0h",
                             reg_write, reg_in, e[35:32], e[31:0]);
                end
            end
        end
    end

    fwd_vec_t fv [3];

    initial begin
        fv[0] = '{4'd5, 1'b1, 32'h2222};
        fv[1] = '{4'd6, 1'b0, 32'h0};
        fv[2] = '{4'hF, 1'b0, 32'h0};

        rst = 1'b1;
        stall = 1'b0;
        rd_addr = 4'hF;
        drive(1'b0, 4'h0, 32'h0);
        tick;
        tick;
        rst = 1'b0;
        chk("rst_count", 32'(count), 0);
        chk("rst_reg_write", 32'(reg_write), 32'hF);
        chk("rst_reg_in", reg_in, 0);
        chk("rst_err", 32'(err), 0);
        chk("rst_ready", 32'(wq.in_ready), 1);

        // Single write latency
        drive(1'b1, 4'd3, 32'hAAAA);
        tick;
        drive(1'b0, 4'd0, 32'h0);
        chk("t1_count1", 32'(count), 1);
        chk("t1_idle_n1", 32'(reg_write), 32'hF);
        tick;
        chk("t1_reg_write", 32'(reg_write), 3);
        chk("t1_reg_in", reg_in, 32'hAAAA);
        chk("t1_count0", 32'(count), 0);
        tick;
        chk("t1_idle_after", 32'(reg_write), 32'hF);
        chk("t1_reg_in_hold", reg_in, 32'hAAAA);

        // Fill under stall, then drain
        stall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 4'(i), 32'h100 + 32'(i));
            tick;
        end
        chk("t2_count_full", 32'(count), 4);
        chk("t2_not_ready", 32'(wq.in_ready), 0);
        drive(1'b1, 4'd9, 32'h999);
        tick;
        drive(1'b0, 4'd0, 32'h0);
        chk("t2_5th_dropped", 32'(count), 4);
        chk("t2_stall_idle", 32'(reg_write), 32'hF);
        stall = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick;
            chk("t2_drain_addr", 32'(reg_write), 32'(i));
        end
        tick;
        chk("t2_drain_done", 32'(reg_write), 32'hF);
        chk("t2_count0", 32'(count), 0);

        // Forwarding
        stall = 1'b1;
        drive(1'b1, 4'd5, 32'h1111);
        tick;
        drive(1'b1, 4'd5, 32'h2222);
        tick;
        drive(1'b1, 4'd7, 32'h77);
        tick;
        drive(1'b0, 4'd0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            rd_addr = fv[i].rd_addr;
            #1;
            chk("t3_hit", 32'(rd_hit), 32'(fv[i].exp_hit));
            chk("t3_data", rd_data, fv[i].exp_data);
        end
        stall = 1'b0;
        tick;
        rd_addr = 4'd5;
        #1;
        chk("t3_queue_over_out", rd_data, 32'h2222);
        tick;
        chk("t3_out_stage_hit", 32'(rd_hit), 1);
        chk("t3_out_stage_data", rd_data, 32'h2222);
        tick;
        rd_addr = 4'd7;
        #1;
        chk("t3_out7", rd_data, 32'h77);
        rd_addr = 4'd5;
        #1;
        chk("t3_miss5", 32'(rd_hit), 0);
        tick;
        rd_addr = 4'd7;
        #1;
        chk("t3_miss_idle", 32'(rd_hit), 0);
        rd_addr = 4'hF;

        // Idle address request
        drive(1'b1, 4'hF, 32'hDEAD);
        tick;
        drive(1'b0, 4'd0, 32'h0);
        chk("t4_err", 32'(err), 1);
        chk("t4_count", 32'(count), 0);
        chk("t4_idle", 32'(reg_write), 32'hF);
        tick;
        chk("t4_err_pulse", 32'(err), 0);
        chk("t4_idle2", 32'(reg_write), 32'hF);

        // Push and pop on the same edge, wrapping the pointers
        stall = 1'b1;
        drive(1'b1, 4'd1, $urandom);
        tick;
        drive(1'b1, 4'd2, $urandom);
        tick;
        stall = 1'b0;
        for (int i = 0; i < 12; i++) begin
            drive(1'b1, 4'(i % 15), $urandom);
            tick;
            chk("t5_count_steady", 32'(count), 2);
        end
        drive(1'b0, 4'd0, 32'h0);
        for (int i = 0; i < 20 && (sb.size() != 0 || count != 0); i++)
            tick;
        tick;
        chk("t5_drained", 32'(sb.size()), 0);
        chk("t5_count0", 32'(count), 0);

        // Reset mid-operation
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 4'(i + 8), 32'h500 + 32'(i));
            tick;
        end
        drive(1'b0, 4'd0, 32'h0);
        chk("t6_count3", 32'(count), 3);
        stall = 1'b0;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        chk("t6_count", 32'(count), 0);
        chk("t6_reg_write", 32'(reg_write), 32'hF);
        chk("t6_reg_in", reg_in, 0);
        chk("t6_ready", 32'(wq.in_ready), 1);
        tick;
        chk("t6_no_drain", 32'(reg_write), 32'hF);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end
endmodule
